latch_q_monitor: RTL



---
 rtl/latch_q_monitor.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/latch_q_monitor.sv
// Synchronizes and debounces the asynchronous d_latch output q, then reports clean edges,
// a saturating transition count and the width of the last high phase. Optional glitch counter: LATCH_Q_MONITOR_GLITCH_CNT_EN.
module latch_q_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q_in,
    input  logic             clr_cnt,
    output logic             q_sync,
    output logic             q_stable,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [CNT_W-1:0] high_width,
    output logic             width_valid
`ifdef LATCH_Q_MONITOR_GLITCH_CNT_EN
    ,
    output logic [CNT_W-1:0] glitch_cnt
`endif
);

    localparam int               STAB_W  = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_LOW,
        ST_CHK_H,
        ST_HIGH,
        ST_CHK_L
    } state_t;

    logic [SYNC_STAGES-1:0] sync_ff;
    state_t                 state;
    state_t                 state_nxt;
    logic [STAB_W-1:0]      stab_cnt;
    logic [STAB_W-1:0]      stab_cnt_nxt;
    logic                   q_stable_nxt;
    logic                   rise_nxt;
    logic                   fall_nxt;
    logic [CNT_W-1:0]       width_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], q_in};
        end
    end

    assign q_sync = sync_ff[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_LOW;
            stab_cnt <= '0;
        end else begin
            state    <= state_nxt;
            stab_cnt <= stab_cnt_nxt;
        end
    end

    // NOTE: defaults at the top of the block keep every path assigned, so no latch is inferred.
    always_comb begin
        state_nxt    = state;
        stab_cnt_nxt = stab_cnt;
        case (state)
            ST_LOW: begin
                if (q_sync) begin
                    if (DEBOUNCE == 1) begin
                        state_nxt = ST_HIGH;
                    end else begin
                        state_nxt    = ST_CHK_H;
                        stab_cnt_nxt = STAB_W'(1);
                    end
                end
            end
            ST_CHK_H: begin
                if (!q_sync) begin
                    state_nxt = ST_LOW;
                end else if (int'(stab_cnt) + 1 >= DEBOUNCE) begin
                    state_nxt = ST_HIGH;
                end else begin
                    stab_cnt_nxt = stab_cnt + 1'b1;
                end
            end
            ST_HIGH: begin
                if (!q_sync) begin
                    if (DEBOUNCE == 1) begin
                        state_nxt = ST_LOW;
                    end else begin
                        state_nxt    = ST_CHK_L;
                        stab_cnt_nxt = STAB_W'(1);
                    end
                end
            end
            ST_CHK_L: begin
                if (q_sync) begin
                    state_nxt = ST_HIGH;
                end else if (int'(stab_cnt) + 1 >= DEBOUNCE) begin
                    state_nxt = ST_LOW;
                end else begin
                    stab_cnt_nxt = stab_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_LOW;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change together with state.
    always_comb begin
        q_stable_nxt = (state_nxt == ST_HIGH) || (state_nxt == ST_CHK_L);
        rise_nxt     = (state_nxt == ST_HIGH) && ((state == ST_LOW) || (state == ST_CHK_H));
        fall_nxt     = (state_nxt == ST_LOW) && ((state == ST_HIGH) || (state == ST_CHK_L));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_stable    <= 1'b0;
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
            width_valid <= 1'b0;
        end else begin
            q_stable    <= q_stable_nxt;
            rise_pulse  <= rise_nxt;
            fall_pulse  <= fall_nxt;
            width_valid <= fall_nxt;
        end
    end

    // Clear beats a coincident count; that transition is intentionally dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
        end else if (clr_cnt) begin
            edge_cnt <= '0;
        end else if ((rise_pulse || fall_pulse) && (edge_cnt != CNT_MAX)) begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_cnt  <= '0;
            high_width <= '0;
        end else begin
            if (rise_nxt) begin
                width_cnt <= CNT_W'(1);
            end else if (q_stable && (width_cnt != CNT_MAX)) begin
                width_cnt <= width_cnt + 1'b1;
            end
            if (fall_nxt) begin
                high_width <= width_cnt;
            end
        end
    end

`ifdef LATCH_Q_MONITOR_GLITCH_CNT_EN
    logic glitch_nxt;

    assign glitch_nxt = ((state == ST_CHK_H) && (state_nxt == ST_LOW)) ||
                        ((state == ST_CHK_L) && (state_nxt == ST_HIGH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_cnt <= '0;
        end else if (clr_cnt) begin
            glitch_cnt <= '0;
        end else if (glitch_nxt && (glitch_cnt != CNT_MAX)) begin
            glitch_cnt <= glitch_cnt + 1'b1;
        end
    end
`endif

endmodule
